// File: rtl/pulse_meter.sv
// Measures low-time and fall-to-fall period of a pulse train, with a profile match flag.
// Optional macro PULSE_METER_SYNC2_EN adds a two-flop input synchroniser.
module pulse_meter #(
  parameter int WIDTH      = 16,
  parameter int EXP_LOW    = 70,
  parameter int EXP_PERIOD = 500,
  parameter int TOL        = 0
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Entrada,
  output logic [WIDTH-1:0] LowWidth,
  output logic [WIDTH-1:0] Period,
  output logic             Valid,
  output logic             Match,
  output logic             Timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;

  localparam logic [WIDTH-1:0]        CNT_MAX   = '1;
  localparam logic [WIDTH-1:0]        CNT_ONE   = WIDTH'(1);
  localparam logic signed [WIDTH:0]   EXP_LOW_S = (WIDTH+1)'(EXP_LOW);
  localparam logic signed [WIDTH:0]   EXP_PER_S = (WIDTH+1)'(EXP_PERIOD);
  localparam logic signed [WIDTH:0]   TOL_S     = (WIDTH+1)'(TOL);

  logic s;

`ifdef PULSE_METER_SYNC2_EN
  logic [1:0] sync_q, sync_d;
  assign sync_d = {sync_q[0], Entrada};
  assign s      = sync_q[1];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) sync_q <= 2'b00;
    else          sync_q <= sync_d;
  end
`else
  assign s = Entrada;
`endif

  logic [1:0]       state_q, state_d;
  logic             prev_q, prev_d;
  logic [WIDTH-1:0] lowcnt_q, lowcnt_d;
  logic [WIDTH-1:0] percnt_q, percnt_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic             timeout_q, timeout_d;

  logic fall, rise;
  assign fall = prev_q & ~s;
  assign rise = ~prev_q & s;

  // Widened signed difference keeps |v - e| free of wrap-around.
  function automatic logic within_tol(input logic [WIDTH-1:0] v, input logic signed [WIDTH:0] e);
    logic signed [WIDTH:0] d;
    d = $signed({1'b0, v}) - e;
    if (d < 0) d = -d;
    return d <= TOL_S;
  endfunction

  always_comb begin
    state_d   = state_q;
    prev_d    = s;
    lowcnt_d  = lowcnt_q;
    percnt_d  = percnt_q;
    low_d     = low_q;
    per_d     = per_q;
    valid_d   = 1'b0;
    match_d   = match_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (fall) begin
          lowcnt_d = CNT_ONE;
          percnt_d = CNT_ONE;
          state_d  = LOW;
        end
      end
      LOW: begin
        if (percnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          lowcnt_d  = '0;
          percnt_d  = '0;
          state_d   = IDLE;
        end else begin
          percnt_d = percnt_q + CNT_ONE;
          if (!s)   lowcnt_d = lowcnt_q + CNT_ONE;
          if (rise) state_d  = HIGH;
        end
      end
      HIGH: begin
        // A terminating fall takes priority over saturation.
        if (fall) begin
          per_d    = percnt_q;
          low_d    = lowcnt_q;
          match_d  = within_tol(lowcnt_q, EXP_LOW_S) && within_tol(percnt_q, EXP_PER_S);
          valid_d  = 1'b1;
          lowcnt_d = CNT_ONE;
          percnt_d = CNT_ONE;
          state_d  = LOW;
        end else if (percnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          lowcnt_d  = '0;
          percnt_d  = '0;
          state_d   = IDLE;
        end else begin
          percnt_d = percnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      prev_q    <= 1'b0;
      lowcnt_q  <= '0;
      percnt_q  <= '0;
      low_q     <= '0;
      per_q     <= '0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      lowcnt_q  <= lowcnt_d;
      percnt_q  <= percnt_d;
      low_q     <= low_d;
      per_q     <= per_d;
      valid_q   <= valid_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
    end
  end

  assign LowWidth = low_q;
  assign Period   = per_q;
  assign Valid    = valid_q;
  assign Match    = match_q;
  assign Timeout  = timeout_q;

endmodule

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Measures the periodic pulse train produced by the neighbouring waveform-generator stage: low-time and period of its single-bit output, in Clock cycles.
- Publishes each completed measurement with a one-cycle valid strobe.
- Flags whether the measurement matches the expected profile (70-cycle low, 500-cycle period), so the generator can be self-checked in system.

Parameters:
- WIDTH, 16, width of the internal counters and of the result outputs.
- EXP_LOW, 70, expected low-time in cycles.
- EXP_PERIOD, 500, expected period in cycles.
- TOL, 0, allowed absolute deviation (cycles) for both values when computing Match.

Ports:
- Clock  input  1  single clock; all state on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Entrada  input  1  pulse train under measurement; same clock domain as Clock.
- LowWidth  output  WIDTH  low-time of the last completed period, in cycles.
- Period  output  WIDTH  last completed period, falling edge to falling edge, in cycles.
- Valid  output  1  one-cycle strobe; LowWidth, Period and Match are updated in the same cycle.
- Match  output  1  last result within TOL of both EXP_LOW and EXP_PERIOD.
- Timeout  output  1  sticky flag: period counter saturated with no falling edge seen.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (Reset_n=0, asynchronous): state=IDLE; counters=0; LowWidth=0; Period=0; Valid=0; Match=0; Timeout=0; edge register prev=0.
- Edge detect:
  - s = Entrada, or the synchronised copy when SYNC2_EN is defined.
  - prev <= s every cycle.
  - fall = prev & ~s; rise = ~prev & s.
  - Because prev resets to 0, an input that is already low at reset does not produce a fall.
- FSM states: IDLE, LOW, HIGH.
  - IDLE: wait for fall. On fall: lowcnt<=1, percnt<=1, go to LOW. No Valid is produced.
  - LOW:
    - percnt increments every cycle.
    - lowcnt increments on every cycle where s=0.
    - On rise: go to HIGH. lowcnt does not increment on the rise cycle.
  - HIGH:
    - percnt increments every cycle except the fall cycle.
    - On fall:
      - Period<=percnt and LowWidth<=lowcnt.
      - Match<=(|lowcnt-EXP_LOW|<=TOL)&&(|percnt-EXP_PERIOD|<=TOL).
      - Valid<=1 for that one cycle.
      - lowcnt<=1, percnt<=1; go to LOW.
- Latency: Valid rises on the clock edge that samples the terminating fall. Results are registered and held until the next Valid.
- First Valid occurs at the second observed falling edge after reset.
- Results: unsigned, WIDTH bits. The Match comparison uses WIDTH+1-bit signed differences, so no wrap-around.
- Saturation:
  - If percnt reaches 2^WIDTH-1 in LOW or HIGH: Timeout<=1, go to IDLE, discard the partial measurement. LowWidth and Period are unchanged; no Valid.
  - Timeout clears only on reset.
- Simultaneous events: fall and saturation in the same cycle → the fall wins; the measurement is published normally.
- A fall in state LOW is impossible (s is already low). A rise while in HIGH or IDLE is ignored.
- Glitches: no filtering. A 1-cycle high pulse is a legal period boundary.
- Reset asserted mid-measurement: everything returns to the reset values immediately; the partial period is discarded.

Optional Feature:
- Macro: PULSE_METER_SYNC2_EN.
- Defined: Entrada passes through a two-flop synchroniser, reset value 0, before edge detection. Every edge is seen 2 cycles later. Measured widths are unchanged; Valid is delayed 2 cycles relative to the undefined build.
- Undefined: Entrada is used directly; Entrada must be synchronous to Clock.

Test Plan:
- Reference waveform (high 20, low 70, high 410, repeating): first Valid at the second fall, then one Valid every 500 cycles, each with LowWidth=70, Period=500, Match=1, Timeout=0.
- Low 10 / period 100 with defaults: Valid every 100 cycles with LowWidth=10, Period=100, Match=0. Rerun with TOL=2, EXP_LOW=11, EXP_PERIOD=98: Match=1.
- Entrada held high forever after one fall, WIDTH=8: no Valid; Timeout=1 when percnt reaches 255; LowWidth and Period stay 0; state returns to IDLE. A later normal train gives Valid again while Timeout stays 1.
- Entrada low at reset release, rising at cycle 5, falling at cycle 8: no Valid until the second fall; the first result covers fall to fall only.
- Reset_n pulsed low 200 cycles into a 500-cycle period: all outputs are 0 asynchronously. The next Valid reports a complete period (500/70), not a partial one.
- PULSE_METER_SYNC2_EN defined with the reference waveform: values are identical to the first scenario; the Valid strobe is exactly 2 cycles later than in the undefined build.
